data_memory_arbiter: RTL and testbench

//  Shares the single-port 128x32 synchronous data memory between two requesters:

---
 rtl/data_memory_arbiter_pkg.sv | 14 +
 rtl/data_memory_arbiter_rr_arbiter2.sv | 22 ++
 rtl/data_memory_arbiter.sv | 122 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and defaults for the two-port data memory arbiter.
package data_memory_arbiter_pkg;

  localparam int unsigned AddrWidthDefault = 7;
  localparam int unsigned DataWidthDefault = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Combinational two-way winner select; the round-robin pointer lives in the parent.
module data_memory_arbiter_rr_arbiter2 #(
  parameter bit FixedPriority = 1'b0
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic valid_o,
  output logic winner_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      // On a tie the port named by the pointer was served last and yields.
      winner_o = FixedPriority ? 1'b0 : ~ptr_i;
    end else begin
      winner_o = req1_i;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port synchronous data memory between two req/ack requesters,
// sequencing the memory's registered read and holding per-port read data.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = AddrWidthDefault,
  parameter int unsigned DATA_WIDTH     = DataWidthDefault,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic grant_valid;
  logic grant_winner;

  data_memory_arbiter_rr_arbiter2 #(
    .FixedPriority (FIXED_PRIORITY)
  ) u_arb (
    .req0_i   (req0),
    .req1_i   (req1),
    .ptr_i    (ptr_q),
    .valid_o  (grant_valid),
    .winner_o (grant_winner)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ptr_d    = ptr_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = StIssue;
          owner_d = grant_winner;
          ptr_d   = grant_winner;
          we_d    = grant_winner ? we1 : we0;
          addr_d  = grant_winner ? addr1 : addr0;
          wdata_d = grant_winner ? wdata1 : wdata0;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        state_d = StDone;
        // mem_q reflects the address presented during ISSUE.
        if (!we_q) begin
          if (owner_q) begin
            rdata1_d = mem_q;
          end else begin
            rdata0_d = mem_q;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ptr_q    <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ptr_q    <= ptr_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decode straight from registers, so reset drops them immediately.
  assign ack0        = (state_q == StDone) && !owner_q;
  assign ack1        = (state_q == StDone) && owner_q;
  assign busy        = (state_q != StIdle);
  assign mem_wren    = (state_q == StIssue) && we_q;
  assign mem_address = addr_q;
  assign mem_data    = wdata_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench: two arbiters (round-robin and fixed priority) each fronting a 128x32 memory.
module tb_data_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [6:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;

  logic        ack0_a, ack1_a, busy_a, mem_wren_a;
  logic [31:0] rdata0_a, rdata1_a, mem_data_a, mem_q_a;
  logic [6:0]  mem_address_a;
  logic        ack0_b, ack1_b, busy_b, mem_wren_b;
  logic [31:0] rdata0_b, rdata1_b, mem_data_b, mem_q_b;
  logic [6:0]  mem_address_b;

  logic [31:0] mem_a [128] = '{default: '0};
  logic [31:0] mem_b [128] = '{default: '0};

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clock = ~clock;

  data_memory_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .FIXED_PRIORITY(1'b0)) u_dut_a (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_a), .ack1(ack1_a), .rdata0(rdata0_a), .rdata1(rdata1_a), .busy(busy_a),
    .mem_address(mem_address_a), .mem_data(mem_data_a), .mem_wren(mem_wren_a),
    .mem_q(mem_q_a)
  );

  data_memory_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .FIXED_PRIORITY(1'b1)) u_dut_b (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_b), .ack1(ack1_b), .rdata0(rdata0_b), .rdata1(rdata1_b), .busy(busy_b),
    .mem_address(mem_address_b), .mem_data(mem_data_b), .mem_wren(mem_wren_b),
    .mem_q(mem_q_b)
  );

  // Behavioural stand-ins for the data_memory3 instances.
  always @(posedge clock) begin
    if (mem_wren_a) mem_a[mem_address_a] <= mem_data_a;
    mem_q_a <= mem_a[mem_address_a];
    if (mem_wren_b) mem_b[mem_address_b] <= mem_data_b;
    mem_q_b <= mem_b[mem_address_b];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_ack", 32'({ack1_a, ack0_a}), 32'd0);
    check_eq("rst_wren", 32'(mem_wren_a), 32'd0);
    check_eq("rst_addr", 32'(mem_address_a), 32'd0);
    check_eq("rst_data", mem_data_a, 32'd0);
    check_eq("rst_rdata0", rdata0_a, 32'd0);
    check_eq("rst_rdata1", rdata1_a, 32'd0);
    reset = 1'b0;
  endtask

  // One handshake on DUT A: returns cycles from request to ack (-1 on timeout).
  task automatic do_txn(input logic port, input logic we, input logic [6:0] addr,
                        input logic [31:0] data, output int lat, output int wren_cnt,
                        output logic [6:0] wr_addr);
    logic ack;
    @(posedge clock); #1;
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data;
    end
    lat = -1; wren_cnt = 0; wr_addr = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (mem_wren_a) begin
        wren_cnt++;
        wr_addr = mem_address_a;
      end
      ack = port ? ack1_a : ack0_a;
      if (ack) begin
        lat = k;
        check_eq("txn_other_ack", 32'(port ? ack0_a : ack1_a), 32'd0);
        break;
      end
    end
    @(posedge clock); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // Transaction-level reference: grant at edge g, memory effect at grant time,
  // ack visible during the interval after edge g+2, next grant no earlier than edge g+4.
  task automatic random_phase(input int n_cycles);
    logic [31:0] ref_mem [128];
    logic        pend [2];
    logic        p_we [2];
    logic [6:0]  p_addr [2];
    logic [31:0] p_data [2];
    logic        seen_ack [2];
    logic [31:0] exp_rdata [2];
    int          g_cyc, free_cyc;
    logic        last_owner, owner, w, m_we;
    logic [6:0]  m_addr;
    logic [31:0] m_data, rd_val;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_data[p] = '0;
      seen_ack[p] = 1'b0; exp_rdata[p] = '0;
    end
    g_cyc = -10; free_cyc = 0; last_owner = 1'b1; owner = 1'b0;
    m_we = 1'b0; m_addr = '0; m_data = '0; rd_val = '0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      @(posedge clock); #1;
      if (cyc >= free_cyc && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) w = ~last_owner;
        else w = pend[1];
        last_owner = w; owner = w; g_cyc = cyc; free_cyc = cyc + 4;
        m_we = p_we[w]; m_addr = p_addr[w]; m_data = p_data[w];
        if (m_we) ref_mem[m_addr] = m_data;
        else rd_val = ref_mem[m_addr];
      end
      if (cyc == g_cyc + 2 && !m_we) exp_rdata[owner] = rd_val;
      for (int p = 0; p < 2; p++) begin
        if (seen_ack[p]) pend[p] = 1'b0;
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]   = 1'b1;
          p_we[p]   = 1'($urandom_range(0, 1));
          p_addr[p] = ($urandom_range(0, 9) == 0) ? 7'd127 : 7'($urandom_range(0, 7));
          p_data[p] = $urandom;
        end
      end
      req0 = pend[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_data[0];
      req1 = pend[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_data[1];
      @(negedge clock);
      check_eq("rnd_ack0", 32'(ack0_a), 32'(cyc == g_cyc + 2 && owner == 1'b0));
      check_eq("rnd_ack1", 32'(ack1_a), 32'(cyc == g_cyc + 2 && owner == 1'b1));
      check_eq("rnd_busy", 32'(busy_a), 32'(cyc >= g_cyc && cyc <= g_cyc + 2));
      check_eq("rnd_wren", 32'(mem_wren_a), 32'(cyc == g_cyc && m_we));
      check_eq("rnd_addr", 32'(mem_address_a), 32'(m_addr));
      check_eq("rnd_data", mem_data_a, m_data);
      check_eq("rnd_rdata0", rdata0_a, exp_rdata[0]);
      check_eq("rnd_rdata1", rdata1_a, exp_rdata[1]);
      seen_ack[0] = ack0_a;
      seen_ack[1] = ack1_a;
    end
  endtask

  initial begin
    int         lat, wcnt;
    logic [6:0] waddr;

    do_reset();
    random_phase(600);

    // Write then cross-port read of the same word.
    do_reset();
    do_txn(1'b0, 1'b1, 7'd5, 32'hDEADBEEF, lat, wcnt, waddr);
    check_eq("t1_lat", 32'(lat), 32'd3);
    check_eq("t1_wren_cycles", 32'(wcnt), 32'd1);
    check_eq("t1_wren_addr", 32'(waddr), 32'd5);
    check_eq("t1_rdata0", rdata0_a, 32'd0);
    do_txn(1'b1, 1'b0, 7'd5, 32'h0, lat, wcnt, waddr);
    check_eq("t2_lat", 32'(lat), 32'd3);
    check_eq("t2_wren_cycles", 32'(wcnt), 32'd0);
    check_eq("t2_rdata1", rdata1_a, 32'hDEADBEEF);
    check_eq("t2_rdata0", rdata0_a, 32'd0);

    // Both held from reset: A alternates starting with port 0, B serves only port 0.
    do_reset();
    @(posedge clock); #1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 7'd1; addr1 = 7'd2;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock);
      @(negedge clock);
      check_eq("t3_ack0", 32'(ack0_a), 32'((k % 4 == 3) && ((k / 4) % 2 == 0)));
      check_eq("t3_ack1", 32'(ack1_a), 32'((k % 4 == 3) && ((k / 4) % 2 == 1)));
      check_eq("t4_fixed_ack0", 32'(ack0_b), 32'(k % 4 == 3));
      check_eq("t4_fixed_ack1", 32'(ack1_b), 32'd0);
    end

    // Reset during ISSUE of a write aborts it; the held request is served afterwards.
    do_reset();
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'd9; wdata0 = 32'h1234_5678;
    @(posedge clock);
    @(negedge clock);
    check_eq("t5_wren_issue", 32'(mem_wren_a), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("t5_wren_forced", 32'(mem_wren_a), 32'd0);
    check_eq("t5_busy", 32'(busy_a), 32'd0);
    check_eq("t5_ack0", 32'(ack0_a), 32'd0);
    repeat (2) begin
      @(negedge clock);
      check_eq("t5_ack0_in_reset", 32'(ack0_a), 32'd0);
    end
    reset = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (ack0_a) begin
        lat = k;
        break;
      end
    end
    check_eq("t5_relat", 32'(lat), 32'd3);
    @(posedge clock); #1;
    req0 = 1'b0; we0 = 1'b0;

    // Top address is used as-is.
    do_txn(1'b0, 1'b1, 7'd127, 32'h0000_00FF, lat, wcnt, waddr);
    check_eq("t6_wlat", 32'(lat), 32'd3);
    check_eq("t6_wren_addr", 32'(waddr), 32'd127);
    do_txn(1'b0, 1'b0, 7'd127, 32'h0, lat, wcnt, waddr);
    check_eq("t6_rlat", 32'(lat), 32'd3);
    check_eq("t6_addr_hold", 32'(mem_address_a), 32'd127);
    check_eq("t6_rdata0", rdata0_a, 32'h0000_00FF);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
